// File: rtl/ppu_stream.sv
// Post-processing stream: per-lane row scale, bias add, optional ReLU and
// round/saturate of systolic accumulator beats, with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for i_start, tables writable
// RUN   | accepting ROWS*TILES input beats
// DRAIN | last beat accepted, waiting for the pipeline to empty
module ppu_stream #(
    parameter int LANES  = 16,
    parameter int ACC_W  = 24,
    parameter int COEF_W = 16,
    parameter int FRAC   = 10,
    parameter int OUT_W  = 18,
    parameter int ROWS   = 16,
    parameter int TILES  = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_cfg_we,
    input  logic                            i_cfg_sel,
    input  logic [$clog2(ROWS)-1:0]         i_cfg_addr,
    input  logic [LANES*COEF_W-1:0]         i_cfg_data,
    input  logic                            i_start,
    input  logic                            i_relu_en,
    input  logic                            i_in_valid,
    output logic                            o_in_ready,
    input  logic [LANES*ACC_W-1:0]          i_in_data,
    output logic                            o_out_valid,
    input  logic                            i_out_ready,
    output logic [LANES*OUT_W-1:0]          o_out_data,
    output logic [$clog2(ROWS*TILES)-1:0]   o_out_addr,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [15:0]                     o_sat_cnt
);
    localparam int RW = $clog2(ROWS);
    localparam int AW = $clog2(ROWS*TILES);
    localparam int TW = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int PW = ACC_W + COEF_W;
    localparam int SW = PW + 1;
    localparam logic [SW-1:0] MAXV = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nxt;

    logic [COEF_W-1:0]        scale_tab [ROWS][LANES];
    logic [COEF_W-1:0]        bias_tab  [ROWS][LANES];
    logic                     relu_q;
    logic [RW-1:0]            row;
    logic [TW-1:0]            tile;
    logic                     s1_valid;
    logic signed [PW-1:0]     s1_prod [LANES];
    logic [COEF_W-1:0]        s1_bias [LANES];
    logic [AW-1:0]            s1_addr;
    logic [OUT_W-1:0]         s2_data [LANES];
    logic [LANES-1:0]         s2_sat;
    logic [16:0]              sat_sum;
    logic                     adv;
    logic                     accept;
    logic                     last_beat;
    logic                     start_ok;
    logic [AW-1:0]            beat_addr;

    // Returns {saturated, result} for one lane.
    function automatic logic [OUT_W:0] post_lane(input logic signed [PW-1:0] prod,
                                                 input logic [COEF_W-1:0] bias,
                                                 input logic relu);
        logic signed [SW-1:0] sum;
        logic [SW-1:0]        mag;
        logic [SW-1:0]        rnd;
        logic [OUT_W-1:0]     res;
        logic                 neg;
        logic                 sat;
        sum = {prod[PW-1], prod} + {{(SW-COEF_W){bias[COEF_W-1]}}, bias};
        if (relu && (sum[SW-1] || sum == '0))
            sum = '0;
        neg = sum[SW-1];
        mag = neg ? (~sum + 1'b1) : sum;
        rnd = (mag >> FRAC) + {{(SW-1){1'b0}}, mag[FRAC-1]};
        sat = 1'b0;
        if (rnd > MAXV) begin
            sat = 1'b1;
            rnd = MAXV;
        end
        res = rnd[OUT_W-1:0];
        if (neg)
            res = ~res + 1'b1;
        return {sat, res};
    endfunction

    assign adv        = !o_out_valid || i_out_ready;
    assign o_in_ready = (state == RUN) && adv;
    assign accept     = i_in_valid && o_in_ready;
    assign last_beat  = (row == RW'(ROWS-1)) && (tile == TW'(TILES-1));
    assign o_busy     = (state != IDLE);
    assign beat_addr  = AW'(int'(tile) * ROWS + int'(row));

    always_comb begin
        state_nxt = state;
        o_done    = 1'b0;
        start_ok  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    start_ok  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (accept && last_beat)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!s1_valid && !o_out_valid) begin
                    o_done    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            relu_q <= 1'b0;
            row    <= '0;
            tile   <= '0;
        end else if (start_ok) begin
            relu_q <= i_relu_en;
            row    <= '0;
            tile   <= '0;
        end else if (accept) begin
            if (row == RW'(ROWS-1)) begin
                row  <= '0;
                tile <= (tile == TW'(TILES-1)) ? '0 : tile + 1'b1;
            end else begin
                row <= row + 1'b1;
            end
        end
    end

    // Tables reset to identity scale and zero bias; writable only when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < LANES; k++) begin
                    scale_tab[r][k] <= COEF_W'(1 << FRAC);
                    bias_tab[r][k]  <= '0;
                end
            end
        end else if (i_cfg_we && !o_busy) begin
            for (int k = 0; k < LANES; k++) begin
                if (i_cfg_sel)
                    bias_tab[i_cfg_addr][k] <= i_cfg_data[k*COEF_W +: COEF_W];
                else
                    scale_tab[i_cfg_addr][k] <= i_cfg_data[k*COEF_W +: COEF_W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            for (int k = 0; k < LANES; k++) begin
                s1_prod[k] <= '0;
                s1_bias[k] <= '0;
            end
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_addr <= beat_addr;
                for (int k = 0; k < LANES; k++) begin
                    s1_prod[k] <= $signed(i_in_data[k*ACC_W +: ACC_W]) * $signed(scale_tab[row][k]);
                    s1_bias[k] <= bias_tab[row][k];
                end
            end
        end
    end

    always_comb begin
        s2_sat = '0;
        for (int k = 0; k < LANES; k++) begin
            s2_data[k] = '0;
            {s2_sat[k], s2_data[k]} = post_lane(s1_prod[k], s1_bias[k], relu_q);
        end
        sat_sum = {1'b0, o_sat_cnt} + 17'($countones(s2_sat));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_addr  <= '0;
            o_sat_cnt   <= '0;
        end else if (start_ok) begin
            o_sat_cnt <= '0;
        end else if (adv) begin
            o_out_valid <= s1_valid;
            if (s1_valid) begin
                o_out_addr <= s1_addr;
                for (int k = 0; k < LANES; k++)
                    o_out_data[k*OUT_W +: OUT_W] <= s2_data[k];
                o_sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_ppu_stream.sv
// Bench for ppu_stream: directed runs scored against an arithmetic model of
// scale/bias/ReLU/round/saturate, plus literal spot values.
module tb_ppu_stream;
    localparam int LANES = 16, ACC_W = 24, COEF_W = 16, FRAC = 10, OUT_W = 18;
    localparam int ROWS = 16, TILES = 4, NB = ROWS*TILES;
    localparam longint OMAX = 131071;

    logic clk, rst_n;
    logic cfg_we, cfg_sel;
    logic [3:0] cfg_addr;
    logic [LANES*COEF_W-1:0] cfg_data;
    logic start, relu_en, in_valid, in_ready;
    logic [LANES*ACC_W-1:0] in_data;
    logic out_valid, out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [5:0] out_addr;
    logic busy, done;
    logic [15:0] sat_cnt;

    ppu_stream #(.LANES(LANES), .ACC_W(ACC_W), .COEF_W(COEF_W), .FRAC(FRAC),
                 .OUT_W(OUT_W), .ROWS(ROWS), .TILES(TILES)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel),
        .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data), .i_start(start),
        .i_relu_en(relu_en), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_data(in_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_data(out_data), .o_out_addr(out_addr), .o_busy(busy),
        .o_done(done), .o_sat_cnt(sat_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [15:0] scale_m [ROWS][LANES];
    logic [15:0] bias_m  [ROWS][LANES];
    bit relu_m;
    int acc_cnt, exp_sat, out_cnt, done_cnt, bp_mode, stall_left;
    bit stalled, done_exp_next, due, stall_prev;
    logic [LANES*OUT_W-1:0] q_data [$];
    int q_addr [$];
    logic [LANES*OUT_W-1:0] out_mem [NB];
    logic [LANES*OUT_W-1:0] held_data, ed;
    logic [5:0] held_addr;
    int ea;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [LANES*OUT_W-1:0] act,
                             input logic [LANES*OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scale/bias are Q.FRAC; rounding by adding half an LSB to the magnitude.
    function automatic longint model_lane(input longint acc, input longint sc, input longint bi,
                                          input bit relu, output bit sat);
        longint sum, mag, r;
        sum = acc * sc + bi;
        if (relu && sum <= 0) sum = 0;
        mag = (sum < 0) ? -sum : sum;
        r = (mag + (longint'(1) << (FRAC-1))) >>> FRAC;
        sat = (r > OMAX);
        if (sat) r = OMAX;
        return (sum < 0) ? -r : r;
    endfunction

    function automatic longint lane(input logic [LANES*OUT_W-1:0] d, input int k);
        logic [OUT_W-1:0] t;
        t = d[k*OUT_W +: OUT_W];
        return longint'($signed(t));
    endfunction

    function automatic logic [LANES*ACC_W-1:0] gen(input int mode, input int b);
        logic [LANES*ACC_W-1:0] d;
        int v;
        d = '0;
        for (int k = 0; k < LANES; k++) begin
            case (mode)
                0: v = 5;
                1: v = (b == 0) ? ((k % 2) ? -3 : 3) :
                       (b == 1) ? 2 : int'($urandom_range(0, 400000)) - 200000;
                2: v = (k % 2) ? -8388608 : 8388607;
                default: v = -7;
            endcase
            d[k*ACC_W +: ACC_W] = 24'(v);
        end
        return d;
    endfunction

    task automatic init_model();
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < LANES; k++) begin
                scale_m[r][k] = 16'h0400;
                bias_m[r][k]  = 16'h0000;
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            due = done_exp_next;
            done_exp_next = 1'b0;
            if (stall_prev) begin
                check_vec("hold_data", out_data, held_data);
                check("hold_addr", out_addr, held_addr);
                check("hold_valid", out_valid, 1);
            end
            stall_prev = out_valid && !out_ready;
            if (stall_prev) begin
                held_data = out_data;
                held_addr = out_addr;
                check("in_ready_in_stall", in_ready, 0);
            end
            if (!busy) check("in_ready_idle", in_ready, 0);
            if (done || due) begin
                check("done_timing", done, due);
                if (done) begin
                    check("sat_cnt", sat_cnt, exp_sat);
                    done_cnt++;
                end
            end
            if (out_valid && out_ready) begin
                if (q_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_output: got addr %0d expected none", out_addr);
                end else begin
                    ed = q_data.pop_front();
                    ea = q_addr.pop_front();
                    check_vec("out_data", out_data, ed);
                    check("out_addr", out_addr, ea);
                    out_mem[ea] = out_data;
                    out_cnt++;
                    if (ea == NB-1) done_exp_next = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                logic [LANES*OUT_W-1:0] e;
                int row;
                longint r;
                bit s;
                row = acc_cnt % ROWS;
                e = '0;
                for (int k = 0; k < LANES; k++) begin
                    r = model_lane(longint'($signed(in_data[k*ACC_W +: ACC_W])),
                                   longint'($signed(scale_m[row][k])),
                                   longint'($signed(bias_m[row][k])), relu_m, s);
                    e[k*OUT_W +: OUT_W] = r[OUT_W-1:0];
                    if (s && exp_sat < 65535) exp_sat++;
                end
                q_data.push_back(e);
                q_addr.push_back(acc_cnt);
                acc_cnt++;
            end
        end
    end

    initial begin
        logic [OUT_W-1:0] r17;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1: begin
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else if (out_cnt >= 10 && !stalled) begin
                        stalled = 1'b1;
                        stall_left = 2;
                        out_ready = 1'b0;
                    end else out_ready = 1'b1;
                end
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic cfg_write(input bit sel, input int addr, input logic [15:0] val, input bit upd);
        cfg_we = 1'b1;
        cfg_sel = sel;
        cfg_addr = 4'(addr);
        cfg_data = {LANES{val}};
        if (upd)
            for (int k = 0; k < LANES; k++)
                if (sel) bias_m[addr][k] = val; else scale_m[addr][k] = val;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_run(input bit relu);
        relu_en = relu;
        relu_m = relu;
        acc_cnt = 0;
        exp_sat = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int mode, input int nbeats, input bit toggle);
        bit got;
        for (int b = 0; b < nbeats; b++) begin
            in_data = gen(mode, b);
            if (toggle && b == 10) relu_en = ~relu_en;
            in_valid = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                if (in_ready) got = 1'b1;
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got no accept expected beat %0d", b);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no o_done expected pulse");
        end
        tick();
    endtask

    task automatic run(input int mode, input bit relu, input bit toggle, input bit ign, input int bp);
        int dc0;
        bp_mode = bp;
        stalled = 1'b0;
        stall_left = 0;
        out_cnt = 0;
        dc0 = done_cnt;
        start_run(relu);
        if (ign) cfg_write(0, 15, 16'h0800, 0);
        feed(mode, NB, toggle);
        wait_done();
        check("beats_out", out_cnt, NB);
        check("queue_empty", q_addr.size(), 0);
        check("done_pulses", done_cnt - dc0, 1);
        check("busy_after_done", busy, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check_vec({tag, "_out_data"}, out_data, '0);
        check({tag, "_out_addr"}, out_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_sat_cnt"}, sat_cnt, 0);
    endtask

    initial begin
        bit s;
        int dc0;
        rst_n = 1'b0;
        cfg_we = 0; cfg_sel = 0; cfg_addr = '0; cfg_data = '0;
        start = 0; relu_en = 0; in_valid = 0; in_data = '0; out_ready = 1'b1;
        bp_mode = 0; stall_left = 0; stalled = 0; done_cnt = 0; out_cnt = 0;
        done_exp_next = 0; stall_prev = 0; acc_cnt = 0; exp_sat = 0;
        init_model();
        repeat (3) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        check("model_1p5_pos", model_lane(3, 1536, 0, 0, s), 5);
        check("model_1p5_neg", model_lane(-3, 1536, 0, 0, s), -5);
        check("model_bias", model_lane(2, 1024, 512, 0, s), 3);
        check("model_sat_pos", model_lane(8388607, 32767, 0, 0, s), 131071);
        check("model_sat_neg", model_lane(-8388608, 32767, 0, 0, s), -131071);
        check("model_relu", model_lane(-7, 1024, 0, 1, s), 0);

        run(0, 0, 0, 1, 0);
        check("lit_default_first", lane(out_mem[0], 0), 5);
        check("lit_default_row15", lane(out_mem[NB-1], 15), 5);

        cfg_write(0, 0, 16'h0600, 1);
        cfg_write(1, 1, 16'h0200, 1);
        run(1, 0, 0, 0, 1);
        check("stall_seen", stalled, 1);
        check("lit_half_up_pos", lane(out_mem[0], 0), 5);
        check("lit_half_up_neg", lane(out_mem[0], 1), -5);
        check("lit_bias_half", lane(out_mem[1], 4), 3);

        for (int r = 0; r < ROWS; r++) cfg_write(0, r, 16'h7FFF, 1);
        cfg_write(1, 1, 16'h0000, 1);
        run(2, 0, 0, 0, 2);
        check("lit_sat_cnt", sat_cnt, 1024);
        check("lit_sat_pos", lane(out_mem[7], 0), 131071);
        check("lit_sat_neg", lane(out_mem[7], 1), -131071);

        for (int r = 0; r < ROWS; r++) cfg_write(0, r, 16'h0400, 1);
        run(3, 1, 1, 0, 0);
        check("lit_relu_on", lane(out_mem[40], 2), 0);
        run(3, 0, 0, 0, 0);
        check("lit_relu_off", lane(out_mem[5], 3), -7);

        cfg_write(0, 3, 16'h7FFF, 1);
        cfg_write(1, 2, 16'h1234, 1);
        dc0 = done_cnt;
        bp_mode = 0;
        out_cnt = 0;
        start_run(0);
        feed(0, 20, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        q_data.delete();
        q_addr.delete();
        init_model();
        done_exp_next = 0;
        stall_prev = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_no_done", done_cnt - dc0, 0);
        run(0, 0, 0, 0, 0);
        check("lit_restored_row3", lane(out_mem[3], 0), 5);
        check("lit_restored_row2", lane(out_mem[18], 9), 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
